// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 @ 60 Hz VGA timing from a 25 MHz pixel clock.
//
// Ports (vga_timing_gen):
//   clk25   in   1  pixel clock, all state changes on its rising edge
//   reset   in   1  synchronous, active-low reset
//   HS      out  1  horizontal sync, active low
//   VS      out  1  vertical sync, active low
//   px_x    out 10  hCount - H_VID_START (mod 1024), valid while vidSel
//   px_y    out 10  vCount - V_VID_START (mod 1024), valid while vidSel
//   vidSel  out  1  high inside the active video region
//
// Helper blocks in this file:
//   vga_counter    10-bit up-counter with active-high sync clear and a
//                  combinational terminal-count flag
//   vga_comparator 10-bit unsigned less-than

module vga_counter #(
    parameter int TERMINAL_COUNT = 799
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] q,
    output logic       tc
);
    localparam logic [9:0] TC_C = 10'(TERMINAL_COUNT);

    logic [9:0] count_q;
    logic [9:0] count_d;

    // Clear dominates enable.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign q  = count_q;
    assign tc = (count_q == TC_C);
endmodule

module vga_comparator (
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic       lt
);
    assign lt = (a < b);
endmodule

module vga_timing_gen #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VID_START = 144,
    parameter int H_VID_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VID_START = 35,
    parameter int V_VID_END   = 515
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       HS,
    output logic       VS,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       vidSel
);
    localparam logic [9:0] H_SYNC_C      = 10'(H_SYNC);
    localparam logic [9:0] H_VID_START_C = 10'(H_VID_START);
    localparam logic [9:0] H_VID_END_C   = 10'(H_VID_END);
    localparam logic [9:0] V_SYNC_C      = 10'(V_SYNC);
    localparam logic [9:0] V_VID_START_C = 10'(V_VID_START);
    localparam logic [9:0] V_VID_END_C   = 10'(V_VID_END);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       tc_h;
    logic       tc_v;
    logic       h_clr;
    logic       v_clr;

    // External reset is active-low; the counters clear active-high.
    // The horizontal counter wraps by clearing at its terminal count; the
    // vertical counter only moves on a line wrap and clears at frame end.
    assign h_clr = ~reset | tc_h;
    assign v_clr = ~reset | (tc_h & tc_v);

    vga_counter #(.TERMINAL_COUNT(H_TOTAL - 1)) u_hcnt (
        .clk   (clk25),
        .reset (h_clr),
        .en    (1'b1),
        .q     (h_count),
        .tc    (tc_h)
    );

    vga_counter #(.TERMINAL_COUNT(V_TOTAL - 1)) u_vcnt (
        .clk   (clk25),
        .reset (v_clr),
        .en    (tc_h),
        .q     (v_count),
        .tc    (tc_v)
    );

    logic lt_hsync;
    logic lt_hstart;
    logic lt_hend;
    logic lt_vsync;
    logic lt_vstart;
    logic lt_vend;

    vga_comparator u_cmp_hsync  (.a(h_count), .b(H_SYNC_C),      .lt(lt_hsync));
    vga_comparator u_cmp_hstart (.a(h_count), .b(H_VID_START_C), .lt(lt_hstart));
    vga_comparator u_cmp_hend   (.a(h_count), .b(H_VID_END_C),   .lt(lt_hend));
    vga_comparator u_cmp_vsync  (.a(v_count), .b(V_SYNC_C),      .lt(lt_vsync));
    vga_comparator u_cmp_vstart (.a(v_count), .b(V_VID_START_C), .lt(lt_vstart));
    vga_comparator u_cmp_vend   (.a(v_count), .b(V_VID_END_C),   .lt(lt_vend));

    assign HS     = ~lt_hsync;
    assign VS     = ~lt_vsync;
    // "x >= start" is expressed as the inverse of "x < start".
    assign vidSel = ~lt_hstart & lt_hend & ~lt_vstart & lt_vend;

    // Wrapping 10-bit subtraction; outside the active region these values
    // are don't-care (e.g. 880/989 at the origin).
    assign px_x = h_count - H_VID_START_C;
    assign px_y = v_count - V_VID_START_C;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// Main instance uses the 640x480 timing; a second instance with a tiny
// 20x12 frame covers whole-frame and frame-wrap behaviour in few cycles.

module tb_vga_timing_gen;
    logic       clk25 = 1'b0;
    logic       reset;
    logic       rst_s;
    logic       hs, vs, vid;
    logic [9:0] px_x, px_y;
    logic       hs_s, vs_s, vid_s;
    logic [9:0] px_x_s, px_y_s;

    int checks = 0;
    int errors = 0;

    always #20 clk25 = ~clk25;

    vga_timing_gen dut (
        .clk25  (clk25),
        .reset  (reset),
        .HS     (hs),
        .VS     (vs),
        .px_x   (px_x),
        .px_y   (px_y),
        .vidSel (vid)
    );

    vga_timing_gen #(
        .H_TOTAL(20), .H_SYNC(3), .H_VID_START(5), .H_VID_END(17),
        .V_TOTAL(12), .V_SYNC(2), .V_VID_START(3), .V_VID_END(10)
    ) dut_s (
        .clk25  (clk25),
        .reset  (rst_s),
        .HS     (hs_s),
        .VS     (vs_s),
        .px_x   (px_x_s),
        .px_y   (px_y_s),
        .vidSel (vid_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // From hCount=0, HS must rise after exactly 96 edges.
    task automatic wait_hs_rise(input string tag);
        int n;
        n = 0;
        while (hs === 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, n, 96);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low, vid_cnt, vs_low, first_idx, last_idx;
        reset = 1'b0;
        rst_s = 1'b0;
        tick();
        tick();

        // Reset state at (0,0)
        chk("rst_hs",   hs,   0);
        chk("rst_vs",   vs,   0);
        chk("rst_vid",  vid,  0);
        chk("rst_px_x", px_x, 880);
        chk("rst_px_y", px_y, 989);

        reset = 1'b1;
        chk("hold_px_x", px_x, 880);
        wait_hs_rise("hs_rise");             // now (96,0)
        chk("hs96_vs", vs, 0);
        chk("hs96_px_x", px_x, 0 - 48 + 1024);

        ticks(704);                          // (0,1)
        chk("line1_px_x", px_x, 880);
        chk("line1_px_y", px_y, 990);
        chk("line1_hs",   hs,   0);
        chk("line1_vs",   vs,   0);

        ticks(800);                          // (0,2)
        chk("line2_vs",   vs,   1);
        chk("line2_px_y", px_y, 991);

        ticks(25600);                        // (0,34)
        ticks(144);                          // (144,34)
        chk("v34_vid",  vid,  0);
        chk("v34_px_x", px_x, 0);
        ticks(656);                          // (0,35)

        hs_low = 0;
        vid_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 143) begin
                chk("h143_vid", vid, 0);
                chk("h143_px_x", px_x, 1023);
            end
            if (i == 144) begin
                chk("h144_vid",  vid,  1);
                chk("h144_px_x", px_x, 0);
                chk("h144_px_y", px_y, 0);
            end
            if (i == 783) begin
                chk("h783_vid",  vid,  1);
                chk("h783_px_x", px_x, 639);
            end
            if (i == 784) begin
                chk("h784_vid",  vid,  0);
                chk("h784_px_x", px_x, 640);
            end
            if (hs === 1'b0) hs_low++;
            if (vid === 1'b1) vid_cnt++;
            tick();
        end
        chk("line35_hs_low", hs_low, 96);
        chk("line35_vid",    vid_cnt, 640);

        ticks(400);                          // (400,36)
        chk("mid_px_x", px_x, 256);
        chk("mid_px_y", px_y, 1);
        chk("mid_vid",  vid,  1);

        reset = 1'b0;
        tick();                              // (0,0)
        chk("mrst_hs",   hs,   0);
        chk("mrst_vs",   vs,   0);
        chk("mrst_vid",  vid,  0);
        chk("mrst_px_x", px_x, 880);
        chk("mrst_px_y", px_y, 989);
        reset = 1'b1;
        wait_hs_rise("hs_rise_after_mrst");

        // Small frame: 20 clocks/line, 12 lines, active h 5..16, v 3..9.
        rst_s = 1'b1;
        for (int f = 0; f < 4; f++) begin
            hs_low = 0;
            vs_low = 0;
            vid_cnt = 0;
            first_idx = -1;
            last_idx = -1;
            for (int i = 0; i < 240; i++) begin
                if (i == 0) begin
                    chk("s_org_px_x", px_x_s, 1019);
                    chk("s_org_px_y", px_y_s, 1021);
                    chk("s_org_hs",   hs_s,   0);
                    chk("s_org_vs",   vs_s,   0);
                end
                if (vid_s === 1'b1) begin
                    if (first_idx < 0) begin
                        first_idx = i;
                        chk("s_first_px_x", px_x_s, 0);
                        chk("s_first_px_y", px_y_s, 0);
                    end
                    last_idx = i;
                    vid_cnt++;
                end
                if (i == 196) begin
                    chk("s_last_px_x", px_x_s, 11);
                    chk("s_last_px_y", px_y_s, 6);
                end
                if (i == 239) begin
                    chk("s_end_px_x", px_x_s, 14);
                    chk("s_end_px_y", px_y_s, 8);
                end
                if (hs_s === 1'b0) hs_low++;
                if (vs_s === 1'b0) vs_low++;
                tick();
            end
            chk("s_hs_low",    hs_low,    36);
            chk("s_vs_low",    vs_low,    40);
            chk("s_vid_cnt",   vid_cnt,   84);
            chk("s_first_idx", first_idx, 65);
            chk("s_last_idx",  last_idx,  196);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
